// File: rtl/hex_string_streamer.sv
// hex_string_streamer
//    Converts a DIGITS-nibble value into a stream of ASCII hex characters,
//    most significant nibble first, using a valid/ready handshake toward a
//    downstream text writer. After the last character is accepted, o_done
//    pulses for one cycle.
//
//    Optional build macro: LEADING_ZERO_BLANK_EN
//       When defined, zero nibbles before the first nonzero nibble go out as
//       ASCII space. The least significant digit is always a digit.
//
// Ports
//    i_clk          clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_start        conversion request, honoured only in IDLE
//    i_value        value to convert (4*DIGITS bits), captured on start
//    i_char_ready   downstream can accept a character
//    o_char         current ASCII character (0x00 when not valid)
//    o_char_valid   o_char holds a character
//    o_last         current character is the least significant digit
//    o_busy         SEND or DONE
//    o_done         one-cycle pulse after the last character transfers
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_start; outputs quiet
// SEND  | presenting characters; advance on o_char_valid && ready
// DONE  | one-cycle o_done pulse, then back to IDLE

module hex_string_streamer #(
   parameter int DIGITS    = 4,
   parameter bit LOWERCASE = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic                  i_char_ready,
   output logic [7:0]            o_char,
   output logic                  o_char_valid,
   output logic                  o_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        nibble;
   logic              accept;
   logic              xfer;
   logic              blank;

   assign nibble = shift_q[W-1 -: 4];
   assign accept = (state_q == S_IDLE) && i_start;
   assign xfer   = (state_q == S_SEND) && i_char_ready;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (LOWERCASE)
         return 8'h57 + {4'h0, n};   // 0x57 + 0xA = 'a'
      else
         return 8'h37 + {4'h0, n};   // 0x37 + 0xA = 'A'
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // High while every nibble sent so far in this string has been zero.
   logic leading_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         leading_q <= 1'b0;
      else if (accept)
         leading_q <= 1'b1;
      else if (xfer && (nibble != 4'h0))
         leading_q <= 1'b0;
   end

   // The final digit is never blanked so a zero value still prints "0".
   assign blank = leading_q && (nibble == 4'h0) && (cnt_q != '0);
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      o_char       = 8'h00;
      o_char_valid = 1'b0;
      o_last       = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d = i_value;
               cnt_d   = CNT_W'(DIGITS - 1);
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            o_busy       = 1'b1;
            o_char_valid = 1'b1;
            o_last       = (cnt_q == '0);
            o_char       = blank ? 8'h20 : hex_ascii(nibble);
            if (xfer) begin
               shift_d = shift_q << 4;
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == '0)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hex_string_streamer.sv
// Testbench for hex_string_streamer. Three instances share clock and reset:
//    0: DIGITS=4, uppercase   1: DIGITS=4, lowercase   2: DIGITS=1, uppercase
// Expected characters come from an arithmetic model of the hex/blanking rules.

module tb_hex_string_streamer;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_v [3];
   logic        ready_v [3];
   logic [15:0] val_v   [3];

   logic [7:0]  char_o  [3];
   logic        valid_o [3];
   logic        last_o  [3];
   logic        busy_o  [3];
   logic        done_o  [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hex_string_streamer #(.DIGITS(4), .LOWERCASE(1'b0)) dut_up (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_value(val_v[0]),
      .i_char_ready(ready_v[0]), .o_char(char_o[0]), .o_char_valid(valid_o[0]),
      .o_last(last_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]));

   hex_string_streamer #(.DIGITS(4), .LOWERCASE(1'b1)) dut_lc (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_value(val_v[1]),
      .i_char_ready(ready_v[1]), .o_char(char_o[1]), .o_char_valid(valid_o[1]),
      .o_last(last_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]));

   hex_string_streamer #(.DIGITS(1), .LOWERCASE(1'b0)) dut_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[2]), .i_value(val_v[2][3:0]),
      .i_char_ready(ready_v[2]), .o_char(char_o[2]), .o_char_valid(valid_o[2]),
      .o_last(last_o[2]), .o_busy(busy_o[2]), .o_done(done_o[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Character idx (0 = most significant) of value printed with 'digits' digits.
   function automatic logic [7:0] model_char(input logic [63:0] value, input int digits,
                                             input int idx, input bit lc);
      logic [63:0] upper;
      logic [3:0]  n;
      upper = value >> (4 * (digits - 1 - idx));
      n     = upper[3:0];
      if (BLANK && (idx != digits - 1) && (upper == 64'd0))
         return 8'h20;
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      return (lc ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
   endfunction

   task automatic chk_quiet(input int s, input string tag);
      chk({tag, " char"},  char_o[s],  8'h00);
      chk({tag, " valid"}, valid_o[s], 1'b0);
      chk({tag, " last"},  last_o[s],  1'b0);
      chk({tag, " busy"},  busy_o[s],  1'b0);
      chk({tag, " done"},  done_o[s],  1'b0);
   endtask

   // Full conversion on instance s. stall_idx/stall_len force a stall on one
   // character; otherwise each character gets a random stall up to max_stall.
   // With inject set, i_start is pulsed with a different value mid-string and
   // during DONE; neither may have any effect.
   task automatic run_string(input int s, input logic [63:0] value, input int digits,
                             input bit lc, input int max_stall, input int stall_idx,
                             input int stall_len, input bit inject);
      int stall;
      logic [63:0] v;
      v = (digits == 16) ? value : (value & ((64'd1 << (4 * digits)) - 1));
      @(negedge clk);
      chk_quiet(s, "pre-start idle");
      val_v[s]   = v[15:0];
      start_v[s] = 1'b1;
      ready_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      val_v[s]   = 16'($urandom);
      for (int idx = 0; idx < digits; idx++) begin
         if (idx == stall_idx) stall = stall_len;
         else stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
         for (int k = 0; k < stall; k++) begin
            ready_v[s] = 1'b0;
            chk("stall valid", valid_o[s], 1'b1);
            chk("stall char",  char_o[s],  model_char(v, digits, idx, lc));
            chk("stall last",  last_o[s],  (idx == digits - 1));
            chk("stall busy",  busy_o[s],  1'b1);
            if (inject && k == 0) begin
               start_v[s] = 1'b1;
               val_v[s]   = ~v[15:0];
            end
            @(negedge clk);
            start_v[s] = 1'b0;
         end
         if (inject && idx == 1) begin
            start_v[s] = 1'b1;
            val_v[s]   = ~v[15:0];
         end
         ready_v[s] = 1'b1;
         chk("char valid", valid_o[s], 1'b1);
         chk("char",       char_o[s],  model_char(v, digits, idx, lc));
         chk("char last",  last_o[s],  (idx == digits - 1));
         chk("char done",  done_o[s],  1'b0);
         @(negedge clk);
         start_v[s] = 1'b0;
      end
      chk("done pulse", done_o[s],  1'b1);
      chk("done valid", valid_o[s], 1'b0);
      chk("done char",  char_o[s],  8'h00);
      chk("done busy",  busy_o[s],  1'b1);
      chk("done last",  last_o[s],  1'b0);
      if (inject) start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      chk_quiet(s, "post-done idle");
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         ready_v[i] = 1'b0;
         val_v[i]   = 16'h0;
      end

      // Reset state
      #12;
      for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_quiet(i, "after reset release");

      // Directed strings
      run_string(0, 64'h1A3F, 4, 1'b0, 0, -1, 0, 1'b0);
      run_string(1, 64'hBEEF, 4, 1'b1, 0,  1, 3, 1'b0);
      run_string(0, 64'h00C0, 4, 1'b0, 0, -1, 0, 1'b0);
      run_string(0, 64'h0000, 4, 1'b0, 0, -1, 0, 1'b0);
      run_string(0, 64'h000F, 4, 1'b0, 1, -1, 0, 1'b0);
      run_string(0, 64'h2468, 4, 1'b0, 0,  2, 2, 1'b1);
      run_string(2, 64'h9,    1, 1'b0, 0, -1, 0, 1'b0);
      run_string(2, 64'h0,    1, 1'b0, 0, -1, 0, 1'b0);
      run_string(2, 64'hC,    1, 1'b0, 2, -1, 0, 1'b1);

      // Reset in the middle of a string
      @(negedge clk);
      val_v[0]   = 16'h1A3F;
      start_v[0] = 1'b1;
      ready_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("abort char0", char_o[0], 8'h31);
      @(negedge clk);
      chk("abort char1", char_o[0], 8'h41);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_quiet(0, "async reset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_quiet(0, "held reset");
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_quiet(0, "post-abort idle");
      end
      run_string(0, 64'h5555, 4, 1'b0, 0, -1, 0, 1'b0);

      // Randomised strings with random stalls and ignored starts
      for (int t = 0; t < 30; t++) begin
         int s;
         logic [63:0] rv;
         s  = int'($urandom_range(0, 2));
         rv = {48'd0, 16'($urandom)};
         if ($urandom_range(0, 3) == 0) rv = rv & 64'h00FF;
         run_string(s, rv, (s == 2) ? 1 : 4, (s == 1), 3, -1, 0, ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
